// File: rtl/keyboard_write_arbiter_pkg.sv
// Shared definitions for the keyboard / processor memory write arbiter.
// Widths, keyboard command addresses and the arbiter state encoding.
package keyboard_write_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] MOVE1     = 12'd64;
    localparam logic [ADDR_W-1:0] MOVE2     = 12'd65;
    localparam logic [ADDR_W-1:0] RESET_CMD = 12'd67;
    localparam logic [ADDR_W-1:0] KILL_CMD  = 12'd68;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        KB   = 2'd2
    } state_e;

endpackage

// File: rtl/keyboard_write_arbiter_kb_write_fifo.sv
// Small synchronous FIFO holding queued keyboard writes {addr, data}.
// Head entry is presented combinationally; push on full is taken only with a pop.
module kb_write_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PW+1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/keyboard_write_arbiter.sv
// Arbitrates the single memory write port between processor stores and
// queued keyboard commands, with a starvation guard for the keyboard side.
module keyboard_write_arbiter #(
    parameter int ADDR_W       = keyboard_write_arbiter_pkg::ADDR_W,
    parameter int DATA_W       = keyboard_write_arbiter_pkg::DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              kb_we,
    input  logic [ADDR_W-1:0] kb_addr,
    input  logic [DATA_W-1:0] kb_data,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              kb_pending,
    output logic              kb_overflow
);

    import keyboard_write_arbiter_pkg::*;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = ADDR_W + DATA_W;

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          r_overflow;
    logic [SW-1:0] r_starve;
    state_e        r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    logic          w_edge;
    logic          w_force;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_empty;
    logic          w_full;
    logic [EW-1:0] w_head;
    state_e        w_next;

    assign w_edge  = r_s2 & ~r_s3;
    assign w_force = (r_starve == SW'(STARVE_LIMIT)) & ~w_empty;
    assign w_pop   = (w_next == KB);
    assign w_push  = w_edge & (~w_full | w_pop);
    assign w_drop  = w_edge & w_full & ~w_pop;

    assign cpu_stall   = w_force;
    assign mem_we      = (r_state != IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign kb_pending  = ~w_empty;
    assign kb_overflow = r_overflow;

    kb_write_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({kb_addr, kb_data}),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // Bring the asynchronous keyboard strobe into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= kb_we;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Port owner for the next cycle; a starved queue overrides the processor.
    always_comb begin
        w_next = IDLE;
        if (w_force) begin
            w_next = KB;
        end else if (cpu_we) begin
            w_next = CPU;
        end else if (!w_empty) begin
            w_next = KB;
        end
    end

    // Register the granted write and track how long the queue has waited.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_starve   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            case (w_next)
                CPU: begin
                    r_mem_addr <= cpu_addr;
                    r_mem_data <= cpu_data;
                end
                KB: begin
                    r_mem_addr <= w_head[EW-1:DATA_W];
                    r_mem_data <= w_head[DATA_W-1:0];
                end
                default: begin
                    r_mem_addr <= r_mem_addr;
                    r_mem_data <= r_mem_data;
                end
            endcase
            if (w_empty || w_next == KB) begin
                r_starve <= '0;
            end else if (w_next == CPU && r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keyboard_write_arbiter.sv
// Directed bench for keyboard_write_arbiter with a write scoreboard.
// A second instance with a long starvation limit exercises queue-full cases.
module tb_keyboard_write_arbiter;

    import keyboard_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kb_we = 1'b0;
    logic [11:0] kb_addr = '0;
    logic [31:0] kb_data = '0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;

    logic        d_cpu_stall, d_mem_we, d_kb_pending, d_kb_overflow;
    logic [11:0] d_mem_addr;
    logic [31:0] d_mem_data;
    logic        b_cpu_stall, b_mem_we, b_kb_pending, b_kb_overflow;
    logic [11:0] b_mem_addr;
    logic [31:0] b_mem_data;

    bit          mon_big = 1'b0;
    logic        m_we, m_pend;
    logic [11:0] m_addr;
    logic [31:0] m_data;

    logic [43:0] kb_q[$];
    logic [43:0] cpu_q[$];
    logic [43:0] exp_e;

    int n_assert = 0;
    int n_fail = 0;
    int kb_writes = 0;
    int cpu_writes = 0;
    int cpu_run = 0;
    int cpu_before_kb = -1;
    int stalls = 0;
    bit cpu_chk = 1'b0;
    bit prev_pend = 1'b0;

    always #5 clk = ~clk;

    keyboard_write_arbiter u_dut (
        .clock       (clk),
        .reset       (rst_n),
        .kb_we       (kb_we),
        .kb_addr     (kb_addr),
        .kb_data     (kb_data),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_stall   (d_cpu_stall),
        .mem_we      (d_mem_we),
        .mem_addr    (d_mem_addr),
        .mem_data    (d_mem_data),
        .kb_pending  (d_kb_pending),
        .kb_overflow (d_kb_overflow)
    );

    keyboard_write_arbiter #(.STARVE_LIMIT(64)) u_big (
        .clock       (clk),
        .reset       (rst_n),
        .kb_we       (kb_we),
        .kb_addr     (kb_addr),
        .kb_data     (kb_data),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_stall   (b_cpu_stall),
        .mem_we      (b_mem_we),
        .mem_addr    (b_mem_addr),
        .mem_data    (b_mem_data),
        .kb_pending  (b_kb_pending),
        .kb_overflow (b_kb_overflow)
    );

    assign m_we   = mon_big ? b_mem_we     : d_mem_we;
    assign m_pend = mon_big ? b_kb_pending : d_kb_pending;
    assign m_addr = mon_big ? b_mem_addr   : d_mem_addr;
    assign m_data = mon_big ? b_mem_data   : d_mem_data;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_kb(input logic [11:0] a);
        return a == MOVE1 || a == MOVE2 || a == RESET_CMD || a == KILL_CMD;
    endfunction

    // Scoreboard: every memory write is matched against the expected streams.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_we) begin
                if (is_kb(m_addr)) begin
                    kb_writes++;
                    cpu_before_kb = cpu_run;
                    cpu_run = 0;
                    chk("kb_write_expected", 64'(kb_q.size() != 0), 64'd1);
                    if (kb_q.size() != 0) begin
                        exp_e = kb_q.pop_front();
                        chk("kb_write_value", 64'({m_addr, m_data}), 64'(exp_e));
                    end
                end else begin
                    cpu_writes++;
                    if (prev_pend) cpu_run++;
                    if (cpu_chk) begin
                        chk("cpu_write_expected", 64'(cpu_q.size() != 0), 64'd1);
                        if (cpu_q.size() != 0) begin
                            exp_e = cpu_q.pop_front();
                            chk("cpu_write_value", 64'({m_addr, m_data}), 64'(exp_e));
                        end
                    end
                end
            end
            prev_pend = m_pend;
        end
    end

    task automatic kb_pulse(input logic [11:0] a, input logic [31:0] d,
                            input int hold, input bit exp);
        @(negedge clk);
        kb_addr = a;
        kb_data = d;
        kb_we = 1'b1;
        if (exp) kb_q.push_back({a, d});
        repeat (hold) @(negedge clk);
        kb_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        kb_we = 1'b0;
        cpu_we = 1'b0;
        kb_q.delete();
        cpu_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        bit stall;
        bit seen;

        #3;
        chk("rst_mem_we", 64'(d_mem_we), 64'd0);
        chk("rst_mem_addr", 64'(d_mem_addr), 64'd0);
        chk("rst_mem_data", 64'(d_mem_data), 64'd0);
        chk("rst_pending", 64'(d_kb_pending), 64'd0);
        chk("rst_overflow", 64'(d_kb_overflow), 64'd0);
        chk("rst_stall", 64'(d_cpu_stall | b_cpu_stall), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Keyboard latency on an idle port.
        @(negedge clk);
        kb_addr = MOVE1;
        kb_data = 32'h13;
        kb_we = 1'b1;
        kb_q.push_back({MOVE1, 32'h13});
        @(negedge clk);
        @(negedge clk);
        chk("lat_k1_we", 64'(d_mem_we), 64'd0);
        @(negedge clk);
        chk("lat_k2_we", 64'(d_mem_we), 64'd0);
        chk("lat_k2_pend", 64'(d_kb_pending), 64'd1);
        @(negedge clk);
        chk("lat_k3_we", 64'(d_mem_we), 64'd1);
        chk("lat_k3_addr", 64'(d_mem_addr), 64'd64);
        chk("lat_k3_data", 64'(d_mem_data), 64'h13);
        kb_we = 1'b0;
        @(negedge clk);
        chk("lat_one_cycle", 64'(d_mem_we), 64'd0);
        chk("lat_pend_clear", 64'(d_kb_pending), 64'd0);

        // Starvation guard under continuous processor stores.
        cpu_run = 0;
        cpu_before_kb = -1;
        cpu_writes = 0;
        kb_writes = 0;
        stalls = 0;
        cpu_chk = 1'b1;
        fork
            begin
                idx = 0;
                cyc = 0;
                while (idx < 20 && cyc < 200) begin
                    @(negedge clk);
                    cpu_we = 1'b1;
                    cpu_addr = 12'h100 + 12'(idx);
                    cpu_data = 32'hC000 + 32'(idx);
                    #1;
                    stall = d_cpu_stall;
                    if (stall) stalls++;
                    @(posedge clk);
                    if (!stall) begin
                        cpu_q.push_back({cpu_addr, cpu_data});
                        idx++;
                    end
                    cyc++;
                end
            end
            begin
                repeat (2) @(negedge clk);
                kb_pulse(KILL_CMD, 32'd1, 4, 1'b1);
            end
        join
        @(negedge clk);
        cpu_we = 1'b0;
        repeat (4) @(negedge clk);
        chk("starve_all_issued", 64'(idx), 64'd20);
        chk("starve_stall_cycles", 64'(stalls), 64'd1);
        chk("starve_cpu_before_kb", 64'(cpu_before_kb), 64'd8);
        chk("starve_cpu_writes", 64'(cpu_writes), 64'd20);
        chk("starve_kb_writes", 64'(kb_writes), 64'd1);
        chk("starve_cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        cpu_chk = 1'b0;

        // Queue overflow while the processor holds the port.
        mon_big = 1'b1;
        do_reset();
        kb_writes = 0;
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_addr = 12'h200;
        cpu_data = 32'h0;
        kb_pulse(MOVE1,     32'hA0, 4, 1'b1);
        kb_pulse(MOVE2,     32'hA1, 4, 1'b1);
        kb_pulse(RESET_CMD, 32'hA2, 4, 1'b1);
        kb_pulse(KILL_CMD,  32'hA3, 4, 1'b1);
        kb_pulse(MOVE1,     32'hA4, 4, 1'b0);
        chk("ovf_set", 64'(b_kb_overflow), 64'd1);
        chk("ovf_pending", 64'(b_kb_pending), 64'd1);
        @(negedge clk);
        cpu_we = 1'b0;
        repeat (8) @(negedge clk);
        chk("ovf_kb_writes", 64'(kb_writes), 64'd4);
        chk("ovf_q_drained", 64'(kb_q.size()), 64'd0);
        chk("ovf_sticky", 64'(b_kb_overflow), 64'd1);
        chk("ovf_pend_clear", 64'(b_kb_pending), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ovf_reset_clear", 64'(b_kb_overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Push into a full queue on the same edge as a pop.
        kb_writes = 0;
        @(negedge clk);
        cpu_we = 1'b1;
        kb_pulse(MOVE1,     32'hB0, 4, 1'b1);
        kb_pulse(MOVE2,     32'hB1, 4, 1'b1);
        kb_pulse(RESET_CMD, 32'hB2, 4, 1'b1);
        kb_pulse(KILL_CMD,  32'hB3, 4, 1'b1);
        @(negedge clk);
        kb_addr = MOVE2;
        kb_data = 32'hB4;
        kb_we = 1'b1;
        kb_q.push_back({MOVE2, 32'hB4});
        @(negedge clk);
        @(negedge clk);
        cpu_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        kb_we = 1'b0;
        repeat (8) @(negedge clk);
        chk("fullpop_no_ovf", 64'(b_kb_overflow), 64'd0);
        chk("fullpop_kb_writes", 64'(kb_writes), 64'd5);
        chk("fullpop_q_drained", 64'(kb_q.size()), 64'd0);

        // A long keyboard strobe yields a single write.
        mon_big = 1'b0;
        do_reset();
        kb_writes = 0;
        kb_pulse(RESET_CMD, 32'h77, 200, 1'b1);
        repeat (6) @(negedge clk);
        chk("hold_one_write", 64'(kb_writes), 64'd1);
        chk("hold_q_drained", 64'(kb_q.size()), 64'd0);

        // Reset while queued entries are draining.
        mon_big = 1'b1;
        do_reset();
        kb_writes = 0;
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_addr = 12'h200;
        kb_pulse(MOVE1,    32'hD0, 4, 1'b1);
        kb_pulse(MOVE2,    32'hD1, 4, 1'b1);
        kb_pulse(KILL_CMD, 32'hD2, 4, 1'b1);
        @(negedge clk);
        cpu_we = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = b_mem_we;
        end
        chk("mid_drain_started", 64'(seen), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(b_mem_we), 64'd0);
        chk("mid_rst_addr", 64'(b_mem_addr), 64'd0);
        chk("mid_rst_data", 64'(b_mem_data), 64'd0);
        chk("mid_rst_pend", 64'(b_kb_pending), 64'd0);
        chk("mid_rst_ovf", 64'(b_kb_overflow), 64'd0);
        kb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        kb_writes = 0;
        cpu_writes = 0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_kb", 64'(kb_writes), 64'd0);
        chk("mid_rst_no_cpu", 64'(cpu_writes), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_write_arbiter.md
# keyboard_write_arbiter

Shares the single game-memory write port between the keyboard input block and the processor store path. Keyboard write requests (move, reset-key and k-key commands at addresses 64/65/67/68) are synchronised, edge-detected and queued in a small FIFO. The FIFO drains into memory whenever the processor is not writing. A starvation counter guarantees keyboard commands reach memory even under continuous processor stores.

## Interface
- ADDR_W, 12, memory word address width
- DATA_W, 32, memory data width
- FIFO_DEPTH, 4, keyboard queue entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive processor-granted cycles tolerated while the queue is non-empty
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- kb_we  in  1  keyboard write request, level, asynchronous to clock, held ≥4 cycles
- kb_addr  in  ADDR_W  keyboard write address, stable while kb_we high
- kb_data  in  DATA_W  keyboard write data, stable while kb_we high
- cpu_we  in  1  processor store request
- cpu_addr  in  ADDR_W  processor store address
- cpu_data  in  DATA_W  processor store data
- cpu_stall  out  1  processor store not accepted this cycle; hold request
- mem_we  out  1  registered memory write enable
- mem_addr  out  ADDR_W  registered memory address
- mem_data  out  DATA_W  registered memory data
- kb_pending  out  1  queue non-empty
- kb_overflow  out  1  sticky: keyboard request dropped on full queue

## Operation
- kb_we passes through a 2-flop synchroniser (s1, s2), then a delay flop s3. edge = s2 & ~s3.
- On edge: push {kb_addr, kb_data}. If the queue is full, drop the request and set kb_overflow. kb_overflow clears only on reset.
- FSM states:
  - IDLE: no write.
  - CPU: processor owns the port.
  - KB: a queue entry is popped.
- Next state, evaluated every cycle:
  - If starve_cnt == STARVE_LIMIT and the queue is non-empty → KB, with cpu_stall=1.
  - Else if cpu_we → CPU.
  - Else if the queue is non-empty → KB.
  - Else → IDLE.
- Entering CPU registers cpu_addr/cpu_data and sets mem_we=1.
- Entering KB registers the head entry, sets mem_we=1, and pops.
- starve_cnt:
  - Increments on each CPU cycle while the queue is non-empty (saturates at STARVE_LIMIT).
  - Clears on any KB cycle or when the queue is empty.
- cpu_stall is combinational and high only in the forced-KB decision cycle. The processor store is written the following cycle.
- Push and pop in the same cycle are both performed; the count is unchanged. A push to a full queue with a simultaneous pop is accepted.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (reset low, asynchronous) clears:
  - mem_we=0, mem_addr=0, mem_data=0
  - kb_pending=0, kb_overflow=0
  - FSM=IDLE
  - s1/s2/s3=0
  - queue pointers, count and starve_cnt=0
- Reset mid-operation discards all queued entries. A kb_we still high after reset release generates a new edge and is re-queued.
- Keyboard latency, port free: kb_we sampled high at edge k → push at edge k+2 → mem_we high after edge k+3.
- Processor latency: cpu_we high at edge n (not stalled) → mem_we high after edge n.
- mem_we is high for exactly one cycle per accepted write.
- A single kb_we pulse produces exactly one write, however long it is held.

## Structure
- Shared package entries:
  - ADDR_W and DATA_W
  - keyboard addresses: MOVE1=64, MOVE2=65, RESET_CMD=67, KILL_CMD=68
  - FSM state enum {IDLE, CPU, KB}
- Sub-module kb_write_fifo: synchronous FIFO with parameters DATA_W+ADDR_W width and FIFO_DEPTH; ports push, pop, din, dout, empty, full.
- The synchroniser, FSM and starvation counter stay in the top module.

## Test plan
- Idle port, kb_we pulse with addr=64, data=0x0000_0013 → one mem_we cycle at 64/0x13 three cycles after the first sampling edge; kb_pending returns to 0.
- cpu_we held 20 cycles, with one keyboard request (addr=68, data=1) queued at cycle 2 → the keyboard write is granted after 8 CPU cycles with cpu_stall=1 for one cycle; no processor store is lost and each is written exactly once in order.
- Five keyboard requests (addresses 64, 65, 67, 68, 64) while cpu_we is held → first four written in FIFO order, fifth dropped, kb_overflow=1 until reset.
- kb_we held 200 cycles → exactly one memory write.
- Three entries queued, reset asserted mid-drain → all outputs 0 immediately, no further mem_we after release.
- Push on full queue in the same cycle as a pop → entry accepted, kb_overflow stays 0, count stays FIFO_DEPTH.
